mmio_fifo: RTL and testbench
============================

# mmio_fifo

Synchronous single-clock FIFO that buffers 64-bit host MMIO write data and returns it on later MMIO reads of the AFU data-port address. It sits between the AFU's CCI-P MMIO decoder and its read-response path. The decoder pushes on a valid write to the data port and pops on a valid read of the same port. The registered `rd_data`/`rd_valid` pair drives the `tx.c2.data` response mux. Status (`count`, `full`, `empty`, sticky error flags) is exposed so the decoder can map it to a status CSR.

## Interface

Parameters:
- `BITS`, 64, data width in bits.
- `DEPTH`, 8, number of entries; must be a power of two and at least 2.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `clr`  in  1  synchronous flush. Empties the FIFO and clears the error flags.
- `wr_en`  in  1  push request; one entry per cycle.
- `wr_data`  in  BITS  data pushed when `wr_en` is accepted.
- `rd_en`  in  1  pop request; one entry per cycle.
- `rd_data`  out  BITS  registered head data from the last successful pop.
- `rd_valid`  out  1  one-cycle pulse; marks `rd_data` as updated by a pop.
- `count`  out  $clog2(DEPTH)+1  current occupancy, from 0 to DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `ovf`  out  1  sticky; set when a push is dropped.
- `udf`  out  1  sticky; set when a pop is requested while empty.

## Operation

- Storage is a DEPTH×BITS register array.
- The write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- `count` is a separate registered counter. `full` and `empty` decode combinationally from the registered `count`.

Acceptance rules, evaluated on the pre-edge state:
- Pop is accepted when `rd_en && !empty`.
- Push is accepted when `wr_en && (!full || rd_en)`. A simultaneous pop frees the slot, so a push on a full FIFO is accepted if a pop happens in the same cycle.
- Push on a full FIFO without `rd_en`: data is dropped, state is unchanged, `ovf` is set to 1.
- Pop on an empty FIFO: `udf` is set to 1, `rd_valid` stays 0, `rd_data` is written to 0, and pointers are unchanged. The MMIO responder returns 0 for this case.
- Push and pop both accepted in the same cycle: both pointers advance and `count` is unchanged.
- There is no bypass. A push into an empty FIFO is not poppable in the same cycle, so a simultaneous `rd_en` counts as an underflow.

Pop response:
- On an accepted pop, `rd_data <= mem[rd_ptr]` and `rd_valid <= 1`.
- On every other cycle `rd_valid <= 0` and `rd_data` holds its value, except in the underflow case above.

Flush:
- `clr` has priority over `wr_en` and `rd_en` in the same cycle.
- `clr` sets both pointers and `count` to 0, and clears `ovf`, `udf` and `rd_valid` to 0.
- `clr` leaves `rd_data` and the array contents unchanged.

Reset:
- `rst` forces pointers, `count`, `rd_data`, `rd_valid`, `ovf` and `udf` to 0. As a result `empty` is 1 and `full` is 0.
- The array is not reset.
- Asserting `rst` mid-operation discards all stored entries immediately, without waiting for a clock edge.

## Timing

- Push-to-status latency is 1 cycle: a push at edge N updates `count`, `full` and `empty` after edge N.
- A write at edge N can be popped by `rd_en` during cycle N+1. `rd_data` and `rd_valid` then appear after edge N+1.
- Pop-to-data latency is 1 cycle. This matches the registered `tx.c2` response path.
- Throughput is one push and one pop per cycle, sustained.
- All outputs are registered or decoded from registered `count` only. There is no combinational path from any input to any output.

## Test plan

1. Reset then idle, BITS=64, DEPTH=8 → `empty`=1, `full`=0, `count`=0, `rd_valid`=0, `rd_data`=0, `ovf`=`udf`=0.
2. Push 0x11, 0x22, 0x33, then pop 3 times → `rd_data` = 0x11, 0x22, 0x33 with a `rd_valid` pulse each, one cycle after each `rd_en`; `empty`=1 at the end.
3. Push 8 values 0xA0–0xA7, then push 0xFF → `full`=1, `count`=8, `ovf`=1. Draining 8 entries returns 0xA0–0xA7 and 0xFF never appears.
4. With the FIFO full, assert `wr_en`=0xB0 and `rd_en` in the same cycle → head is returned, `count` stays 8, `ovf` stays 0. Pointer wrap is verified by 20 further push/pop pairs returning the data in order.
5. Pop while empty → `udf`=1, `rd_valid`=0, `rd_data`=0. Then push 0x5 with `rd_en` in the same cycle → `count`=1, and the next pop returns 0x5.
6. Fill 4 entries, then assert `clr` together with `wr_en` and `rd_en` → `count`=0, `empty`=1, `ovf`=`udf`=0, no `rd_valid`. Asserting `rst` asynchronously mid-burst zeroes all outputs before the next edge.

Source files
------------

// File: rtl/mmio_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : mmio_fifo                                                     |
// | Purpose  : Single-clock FIFO buffering host MMIO write data for later    |
// |            MMIO reads of the AFU data port. Registered pop response,     |
// |            occupancy counter and sticky overflow/underflow flags.        |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mmio_fifo #(
  parameter int BITS  = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [BITS-1:0]          wr_data,
  input  logic                     rd_en,
  output logic [BITS-1:0]          rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     ovf,
  output logic                     udf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;

  logic pop_ok;
  logic push_ok;
  logic push_drop;
  logic pop_empty;

  // Status decodes purely from the registered occupancy counter.
  assign full  = (count == FULL_COUNT);
  assign empty = (count == '0);

  // Acceptance is judged on pre-edge state; a pop in the same cycle frees
  // the slot a push into a full FIFO needs. No bypass: an empty FIFO never pops.
  always_comb begin
    pop_ok    = rd_en && !empty;
    push_ok   = wr_en && (!full || rd_en);
    push_drop = wr_en && full && !rd_en;
    pop_empty = rd_en && empty;
  end

  // Storage array: written on accepted pushes, never reset, untouched by flush.
  always_ff @(posedge clk) begin
    if (push_ok && !clr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, pop response and sticky error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (clr) begin
      // Flush wins over any push/pop this cycle; rd_data is kept as-is.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_valid <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      rd_valid <= pop_ok;
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + AW'(1);
        rd_data <= mem[rd_ptr];
      end else if (pop_empty) begin
        // The responder returns zero for a read of an empty data port.
        rd_data <= '0;
      end
      count <= count + CW'(push_ok) - CW'(pop_ok);
      if (push_drop) begin
        ovf <= 1'b1;
      end
      if (pop_empty) begin
        udf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_mmio_fifo                                                  |
// | Purpose  : Self-checking bench for mmio_fifo against a queue-based       |
// |            behavioural model of the FIFO rules.                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mmio_fifo;

  localparam int BITS  = 64;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int SW    = CW + 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            clr;
  logic            wr_en;
  logic [BITS-1:0] wr_data;
  logic            rd_en;
  logic [BITS-1:0] rd_data;
  logic            rd_valid;
  logic [CW-1:0]   count;
  logic            full;
  logic            empty;
  logic            ovf;
  logic            udf;

  int nvec = 0;
  int nerr = 0;

  // Behavioural model state
  logic [BITS-1:0] q[$];
  logic [BITS-1:0] m_rdata = '0;
  logic            m_valid = 1'b0;
  logic            m_ovf   = 1'b0;
  logic            m_udf   = 1'b0;

  logic [SW-1:0] got_s;
  logic [SW-1:0] exp_s;

  mmio_fifo #(.BITS(BITS), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full),
    .empty    (empty),
    .ovf      (ovf),
    .udf      (udf)
  );

  always #5 clk = ~clk;

  assign got_s = {count, full, empty, ovf, udf, rd_valid};

  function automatic logic [SW-1:0] model_status();
    int n;
    n = q.size();
    return {CW'(n), (n == DEPTH), (n == 0), m_ovf, m_udf, m_valid};
  endfunction

  // Apply one cycle of stimulus and advance the model from pre-edge state.
  task automatic drive(input logic w, input logic [BITS-1:0] wd,
                       input logic r, input logic c);
    int n;
    logic pop;
    logic push;
    wr_en = w; wr_data = wd; rd_en = r; clr = c;
    @(posedge clk);
    n = q.size();
    if (c) begin
      q.delete();
      m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    end else begin
      pop  = r && (n > 0);
      push = w && ((n < DEPTH) || r);
      m_valid = pop;
      if (pop) m_rdata = q.pop_front();
      else if (r) begin m_udf = 1'b1; m_rdata = '0; end
      if (push) q.push_back(wd);
      else if (w) m_ovf = 1'b1;
    end
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0; wr_data = '0;
  endtask

  task automatic test_reset();
    nvec++;
    if (got_s !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL reset_status: got %b exp %b", got_s, {CW'(0), 5'b01000});
    end
    nvec++;
    if (rd_data !== '0) begin
      nerr++; $display("FAIL reset_rd_data: got %h exp 0", rd_data);
    end
  endtask

  task automatic test_order();
    logic [BITS-1:0] vals[3];
    vals[0] = 64'h11; vals[1] = 64'h22; vals[2] = 64'h33;
    for (int i = 0; i < 3; i++) drive(1'b1, vals[i], 1'b0, 1'b0);
    nvec++;
    if (count !== CW'(3)) begin
      nerr++; $display("FAIL order_count: got %0d exp 3", count);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      nvec++;
      if (rd_valid !== 1'b1 || rd_data !== vals[i]) begin
        nerr++; $display("FAIL order_pop%0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, vals[i]);
      end
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    nvec++;
    if (empty !== 1'b1 || rd_valid !== 1'b0) begin
      nerr++; $display("FAIL order_end: got empty=%b v=%b exp empty=1 v=0", empty, rd_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 64'hA0 + 64'(i), 1'b0, 1'b0);
    drive(1'b1, 64'hFF, 1'b0, 1'b0);
    nvec++;
    if (full !== 1'b1 || count !== CW'(DEPTH) || ovf !== 1'b1) begin
      nerr++; $display("FAIL ovf_status: got full=%b count=%0d ovf=%b exp 1 %0d 1", full, count, ovf, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, '0, 1'b1, 1'b0);
      nvec++;
      if (rd_valid !== 1'b1 || rd_data !== 64'hA0 + 64'(i)) begin
        nerr++; $display("FAIL ovf_drain%0d: got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 64'hA0 + 64'(i));
      end
    end
    nvec++;
    if (got_s !== model_status() || ovf !== 1'b1) begin
      nerr++; $display("FAIL ovf_sticky: got %b exp %b", got_s, model_status());
    end
  endtask

  task automatic test_full_simul();
    logic [BITS-1:0] exp_d;
    drive(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 64'hC0 + 64'(i), 1'b0, 1'b0);
    drive(1'b1, 64'hB0, 1'b1, 1'b0);
    nvec++;
    if (rd_data !== 64'hC0 || rd_valid !== 1'b1 || count !== CW'(DEPTH) || ovf !== 1'b0) begin
      nerr++; $display("FAIL full_simul: got d=%h v=%b count=%0d ovf=%b exp d=c0 v=1 count=%0d ovf=0", rd_data, rd_valid, count, ovf, DEPTH);
    end
    for (int i = 0; i < 20; i++) begin
      exp_d = q[0];
      drive(1'b1, 64'h1000 + 64'(i), 1'b1, 1'b0);
      nvec++;
      if (rd_data !== exp_d || got_s !== model_status()) begin
        nerr++; $display("FAIL wrap_pair%0d: got d=%h s=%b exp d=%h s=%b", i, rd_data, got_s, exp_d, model_status());
      end
    end
    while (q.size() > 0) begin
      exp_d = q[0];
      drive(1'b0, '0, 1'b1, 1'b0);
      nvec++;
      if (rd_data !== exp_d || rd_valid !== 1'b1) begin
        nerr++; $display("FAIL wrap_drain: got d=%h v=%b exp d=%h v=1", rd_data, rd_valid, exp_d);
      end
    end
  endtask

  task automatic test_underflow();
    drive(1'b0, '0, 1'b1, 1'b0);
    nvec++;
    if (udf !== 1'b1 || rd_valid !== 1'b0 || rd_data !== '0) begin
      nerr++; $display("FAIL udf_pop: got udf=%b v=%b d=%h exp 1 0 0", udf, rd_valid, rd_data);
    end
    drive(1'b1, 64'h5, 1'b1, 1'b0);
    nvec++;
    if (count !== CW'(1) || rd_valid !== 1'b0) begin
      nerr++; $display("FAIL udf_nobypass: got count=%0d v=%b exp 1 0", count, rd_valid);
    end
    drive(1'b0, '0, 1'b1, 1'b0);
    nvec++;
    if (rd_data !== 64'h5 || rd_valid !== 1'b1 || empty !== 1'b1) begin
      nerr++; $display("FAIL udf_next: got d=%h v=%b empty=%b exp 5 1 1", rd_data, rd_valid, empty);
    end
  endtask

  task automatic test_clr();
    for (int i = 0; i < 4; i++) drive(1'b1, 64'hD0 + 64'(i), 1'b0, 1'b0);
    drive(1'b1, 64'hEE, 1'b1, 1'b1);
    nvec++;
    if (got_s !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      nerr++; $display("FAIL clr_status: got %b exp %b", got_s, {CW'(0), 5'b01000});
    end
    nvec++;
    if (rd_data !== m_rdata) begin
      nerr++; $display("FAIL clr_rd_data_hold: got %h exp %h", rd_data, m_rdata);
    end
  endtask

  task automatic test_async_rst();
    for (int i = 0; i < 3; i++) drive(1'b1, 64'h77 + 64'(i), 1'b0, 1'b0);
    drive(1'b0, '0, 1'b1, 1'b0);
    nvec++;
    if (rd_valid !== 1'b1 || rd_data !== 64'h77 || count !== CW'(2)) begin
      nerr++; $display("FAIL arst_pre: got v=%b d=%h count=%0d exp 1 77 2", rd_valid, rd_data, count);
    end
    #2 rst = 1'b1;
    #1;
    nvec++;
    if (got_s !== {CW'(0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0} || rd_data !== '0) begin
      nerr++; $display("FAIL arst_async: got s=%b d=%h exp s=%b d=0", got_s, rd_data, {CW'(0), 5'b01000});
    end
    q.delete(); m_rdata = '0; m_valid = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
    #2 rst = 1'b0;
  endtask

  task automatic test_random();
    logic w;
    logic r;
    logic c;
    for (int i = 0; i < 400; i++) begin
      if ((i / 50) % 2 == 0) begin
        w = ($urandom_range(0, 99) < 75);
        r = ($urandom_range(0, 99) < 35);
      end else begin
        w = ($urandom_range(0, 99) < 35);
        r = ($urandom_range(0, 99) < 75);
      end
      c = ($urandom_range(0, 99) == 0);
      drive(w, {$urandom, $urandom}, r, c);
      exp_s = model_status();
      nvec++;
      if (got_s !== exp_s) begin
        nerr++; $display("FAIL rnd_status cyc=%0d: got %b exp %b", i, got_s, exp_s);
      end
      nvec++;
      if (rd_data !== m_rdata) begin
        nerr++; $display("FAIL rnd_rd_data cyc=%0d: got %h exp %h", i, rd_data, m_rdata);
      end
    end
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_order();
    test_overflow();
    test_full_simul();
    test_underflow();
    test_clr();
    test_async_rst();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
